// File: rtl/cipher_stream_engine.sv
// cipher_stream_engine
//   Handshaked chunk-serial encrypt/decrypt engine. A request is accepted in
//   IDLE, then one CHUNK_W-bit chunk is processed per cycle in RUN using an LFSR
//   keystream seeded from key ^ nonce. The result is held in DONE until the
//   consumer takes it. Encrypt draws its nonce from an internal counter and
//   prepends it to the ciphertext. Decrypt takes the nonce from the top of
//   in_data.
//
// Ports
//   Clk        clock, all logic on the rising edge
//   Rst        synchronous reset, active-high
//   in_valid   request valid
//   in_ready   engine idle and able to accept a request
//   in_mode    0 = encrypt, 1 = decrypt
//   in_data    enc: plaintext in [DATA_W-1:0]; dec: {nonce, cipher}
//   key        key, sampled on accept
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_mode   mode of the request that produced out_data
//   out_data   enc: {nonce, cipher}; dec: {zeros, plaintext}
//   busy       high while a request is in flight (RUN or DONE)
module cipher_stream_engine #(
    parameter int CHUNK_W    = 6,
    parameter int NUM_CHUNKS = 10,
    parameter int NONCE_W    = 18,
    parameter int LFSR_TAP   = 10,
    localparam int DATA_W    = CHUNK_W * NUM_CHUNKS,
    localparam int ENC_W     = NONCE_W + DATA_W
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [ENC_W-1:0] in_data,
    input  logic [NONCE_W-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [ENC_W-1:0] out_data,
    output logic             busy
);

    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [IDX_W-1:0]   chunkIdx;
    logic [NONCE_W-1:0] nonceCnt;
    logic               modeReg;
    logic [NONCE_W-1:0] nonceReg;
    logic [NONCE_W-1:0] lfsr;
    logic [DATA_W-1:0]  dataReg;

    logic               accept;
    logic               lastChunk;
    logic [NONCE_W-1:0] nonceSel;
    logic [NONCE_W-1:0] nonceP1;
    logic [NONCE_W-1:0] nonceInc;
    logic [NONCE_W-1:0] seedRaw;
    logic [NONCE_W-1:0] seed;
    logic [NONCE_W-1:0] lfsrNext;
    logic [CHUNK_W-1:0] chunkOut;
    logic [DATA_W-1:0]  dataNext;

    function automatic logic [CHUNK_W-1:0] encryptChunk(
        input logic [CHUNK_W-1:0] p,
        input logic [CHUNK_W-1:0] ks,
        input logic [CHUNK_W-1:0] idx
    );
        return (p ^ ks) + idx;
    endfunction

    function automatic logic [CHUNK_W-1:0] decryptChunk(
        input logic [CHUNK_W-1:0] c,
        input logic [CHUNK_W-1:0] ks,
        input logic [CHUNK_W-1:0] idx
    );
        return (c - idx) ^ ks;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid & in_ready;
    assign lastChunk = (chunkIdx == IDX_W'(NUM_CHUNKS - 1));

    // Nonce counter wraps past zero straight to one so a nonce is never zero.
    assign nonceP1  = nonceCnt + NONCE_W'(1);
    assign nonceInc = (nonceP1 == '0) ? NONCE_W'(1) : nonceP1;
    assign nonceSel = in_mode ? in_data[ENC_W-1 -: NONCE_W] : nonceCnt;

    // An all-zero seed would lock the LFSR at zero.
    assign seedRaw  = key ^ nonceSel;
    assign seed     = (seedRaw == '0) ? NONCE_W'(1) : seedRaw;
    assign lfsrNext = {lfsr[NONCE_W-2:0], lfsr[NONCE_W-1] ^ lfsr[LFSR_TAP]};

    // The low chunk of dataReg is always the current input chunk. Each result
    // enters at the top, so after NUM_CHUNKS shifts the word is in order.
    assign chunkOut = modeReg
        ? decryptChunk(dataReg[CHUNK_W-1:0], lfsr[CHUNK_W-1:0], CHUNK_W'(chunkIdx))
        : encryptChunk(dataReg[CHUNK_W-1:0], lfsr[CHUNK_W-1:0], CHUNK_W'(chunkIdx));
    assign dataNext = {chunkOut, dataReg[DATA_W-1:CHUNK_W]};

    // Control and output registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            chunkIdx <= '0;
            nonceCnt <= NONCE_W'(1);
            out_mode <= 1'b0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= RUN;
                        chunkIdx <= '0;
                        if (!in_mode) nonceCnt <= nonceInc;
                    end
                end
                RUN: begin
                    if (lastChunk) begin
                        state    <= DONE;
                        chunkIdx <= '0;
                        out_mode <= modeReg;
                        out_data <= {(modeReg ? NONCE_W'(0) : nonceReg), dataNext};
                    end else begin
                        chunkIdx <= chunkIdx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge Clk) begin
        if (accept) begin
            modeReg  <= in_mode;
            nonceReg <= nonceSel;
            lfsr     <= seed;
            dataReg  <= in_data[DATA_W-1:0];
        end else if (state == RUN) begin
            lfsr    <= lfsrNext;
            dataReg <= dataNext;
        end
    end

endmodule
